// File: rtl/block_allocator.sv
// block_allocator: single-FSM owner of a block RAM port servicing next-fit ALLOC, FREE and MARK
// requests over req/ready/done, with a live free-block count and optional header clear after reset.
module block_allocator #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int BLOCK_W    = 5,
   parameter int INIT_CLEAR = 1
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic                      req,
   input  logic [1:0]                op,
   input  logic [ADDR_W-1:0]         arg_addr,
   output logic                      ready,
   output logic                      done,
   output logic                      ok,
   output logic [ADDR_W-1:0]         out_address,
   output logic [ADDR_W-BLOCK_W-1:0] free_count,
   output logic [ADDR_W-1:0]         ram_address,
   output logic                      ram_clock,
   output logic [DATA_W-1:0]         ram_data,
   output logic                      ram_wren,
   input  logic [DATA_W-1:0]         ram_q
);
   localparam int NBW = ADDR_W - BLOCK_W;
   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(1) << BLOCK_W;
   localparam logic [ADDR_W-1:0] LAST = -STRIDE;
   localparam logic [NBW-1:0] FULL = '1;
   localparam logic [1:0] ALLOC = 2'd0, FREE = 2'd1, MARK = 2'd2;

   typedef enum logic [2:0] {INIT, IDLE, SCAN, RD, CHK, FIN} state_t;

   state_t state;
   logic [1:0] op_r;
   logic [ADDR_W-1:0] ptr, d1;
   logic [NBW-1:0] cnt;
   logic good, flag, bad_arg;

   assign ram_clock = clock;
   assign flag = ram_q[DATA_W-1];
   assign bad_arg = (|arg_addr[BLOCK_W-1:0]) || arg_addr == '0;
   assign ram_data = {state != INIT && op_r != FREE, {(DATA_W-1){1'b0}}};

   // block index advance that skips the null block 0
   function automatic logic [ADDR_W-1:0] nxt(input logic [ADDR_W-1:0] a);
      return (a == LAST) ? STRIDE : a + STRIDE;
   endfunction

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state       <= INIT_CLEAR != 0 ? INIT : IDLE;
         ready       <= 1'b0;
         done        <= 1'b0;
         ok          <= 1'b0;
         out_address <= '0;
         ram_address <= '0;
         ram_wren    <= 1'b0;
         ptr         <= STRIDE;
         free_count  <= FULL;
         op_r        <= ALLOC;
         d1          <= '0;
         cnt         <= '0;
         good        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            INIT:
               if (!ram_wren) begin
                  ram_address <= STRIDE;
                  ram_wren    <= 1'b1;
               end else if (ram_address == LAST) begin
                  ram_wren <= 1'b0;
                  ready    <= 1'b1;
                  state    <= IDLE;
               end else
                  ram_address <= ram_address + STRIDE;
            IDLE: begin
               ready <= 1'b1;
               if (req && ready) begin
                  op_r <= op;
                  if (op == ALLOC && free_count != '0) begin
                     ram_address <= ptr;
                     cnt         <= '0;
                     ready       <= 1'b0;
                     state       <= SCAN;
                  end else if ((op == FREE || op == MARK) && !bad_arg) begin
                     ram_address <= arg_addr;
                     ready       <= 1'b0;
                     state       <= RD;
                  end else begin
                     done <= 1'b1;
                     ok   <= 1'b0;
                  end
               end
            end
            // one probe issued per clock; d1 tracks the address whose header is on ram_q
            SCAN:
               if (cnt != '0 && !flag) begin
                  ram_address <= d1;
                  ram_wren    <= 1'b1;
                  good        <= 1'b1;
                  state       <= FIN;
               end else if (cnt == FULL) begin
                  good  <= 1'b0;
                  state <= FIN;
               end else begin
                  d1          <= ram_address;
                  ram_address <= nxt(ram_address);
                  cnt         <= cnt + 1'b1;
               end
            RD: state <= CHK;
            CHK: begin
               good     <= flag == (op_r == FREE);
               ram_wren <= flag == (op_r == FREE);
               state    <= FIN;
            end
            FIN: begin
               ram_wren <= 1'b0;
               done     <= 1'b1;
               ok       <= good;
               ready    <= 1'b1;
               state    <= IDLE;
               if (good) begin
                  free_count <= op_r == FREE ? free_count + 1'b1 : free_count - 1'b1;
                  if (op_r == ALLOC) begin
                     out_address <= ram_address;
                     ptr         <= nxt(ram_address);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_block_allocator.sv
// tb_block_allocator: directed and random ALLOC/FREE/MARK traffic against a block-level
// occupancy model, with a behavioural RAM that reads back as allocated until written.
module tb_block_allocator;
   localparam int NB = 32;

   logic clock = 1'b0, resetn = 1'b0, req = 1'b0;
   logic [1:0] op = 2'd0;
   logic [9:0] arg_addr = '0;
   logic ready, done, ok, ram_clock, ram_wren;
   logic [9:0] out_address, ram_address;
   logic [4:0] free_count;
   logic [31:0] ram_data, ram_q;

   logic [31:0] mem [1024];
   bit wrt [1024];
   bit corrupt = 0;

   bit alloc_m [NB];
   int cnt_m, ptr_m, last_m;
   int pass_n = 0, total_n = 0, lat, wr;

   block_allocator dut (
      .clock(clock), .resetn(resetn), .req(req), .op(op), .arg_addr(arg_addr),
      .ready(ready), .done(done), .ok(ok), .out_address(out_address), .free_count(free_count),
      .ram_address(ram_address), .ram_clock(ram_clock), .ram_data(ram_data),
      .ram_wren(ram_wren), .ram_q(ram_q)
   );

   always #5 clock = ~clock;

   // unwritten words read as allocated garbage so the header clear is observable
   always @(posedge ram_clock) begin
      if (ram_wren) begin
         mem[ram_address] <= ram_data;
         wrt[ram_address] <= 1'b1;
      end
      ram_q <= (wrt[ram_address] ? mem[ram_address] : 32'hdead_beef) | (corrupt ? 32'h8000_0000 : 32'h0);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_n++;
      assert (got === exp) pass_n++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
   endtask

   task automatic model_reset();
      for (int b = 0; b < NB; b++) alloc_m[b] = 0;
      cnt_m = NB - 1;
      ptr_m = 1;
      last_m = 0;
   endtask

   task automatic model(input logic [1:0] o, input int a, output bit e_ok, output int e_lat, output int e_wr);
      int b;
      e_ok = 0; e_lat = 1; e_wr = 0;
      if (o == 2'd0) begin
         if (cnt_m > 0) begin
            b = ptr_m;
            for (int k = 1; k < NB; k++) begin
               if (!alloc_m[b]) begin
                  alloc_m[b] = 1; cnt_m--; last_m = b * 32;
                  ptr_m = (b == NB - 1) ? 1 : b + 1;
                  e_ok = 1; e_lat = k + 3; e_wr = 1;
                  break;
               end
               b = (b == NB - 1) ? 1 : b + 1;
            end
         end
      end else if (o != 2'd3 && a % 32 == 0 && a != 0) begin
         b = a / 32;
         e_lat = 4;
         if (alloc_m[b] == (o == 2'd1)) begin
            alloc_m[b] = (o == 2'd2);
            cnt_m += (o == 2'd1) ? 1 : -1;
            e_ok = 1; e_wr = 1;
         end
      end
   endtask

   task automatic drive(input logic [1:0] o, input logic [9:0] a);
      int n = 0;
      while (!ready && n < 200) begin @(negedge clock); n++; end
      op = o; arg_addr = a; req = 1'b1;
      @(posedge clock);
      #1 req = 1'b0; op = 2'($urandom); arg_addr = 10'($urandom);
      lat = 0; wr = 0;
      do begin
         @(negedge clock);
         lat++;
         if (ram_wren) wr++;
      end while (!done && lat < 200);
   endtask

   task automatic do_op(input string tag, input logic [1:0] o, input logic [9:0] a);
      bit e_ok; int e_lat, e_wr;
      model(o, int'(a), e_ok, e_lat, e_wr);
      drive(o, a);
      chk({tag, "_ok"}, 32'(ok), 32'(e_ok));
      chk({tag, "_lat"}, lat, e_lat);
      chk({tag, "_wren"}, wr, e_wr);
      chk({tag, "_count"}, 32'(free_count), cnt_m);
      chk({tag, "_addr"}, 32'(out_address), last_m);
      chk({tag, "_ready"}, 32'(ready), 1);
   endtask

   task automatic init_check();
      int n = 0, cyc = 0;
      @(negedge clock) resetn = 1'b1;
      while (!ready && cyc < 100) begin
         @(negedge clock);
         cyc++;
         if (ram_wren) begin
            n++;
            chk("init_addr", 32'(ram_address), n * 32);
            chk("init_data", ram_data, 0);
         end
      end
      chk("init_wren_cycles", n, NB - 1);
      chk("init_ready", 32'(ready), 1);
      chk("init_count", 32'(free_count), NB - 1);
      model_reset();
   endtask

   initial begin
      int r, b, n;
      #23;
      chk("rst_ready", 32'(ready), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_ok", 32'(ok), 0);
      chk("rst_out", 32'(out_address), 0);
      chk("rst_ram_addr", 32'(ram_address), 0);
      chk("rst_wren", 32'(ram_wren), 0);
      chk("rst_count", 32'(free_count), NB - 1);
      init_check();

      do_op("alloc1", 2'd0, 0);
      do_op("alloc2", 2'd0, 0);
      do_op("alloc3", 2'd0, 0);
      chk("alloc3_is_96", 32'(out_address), 96);
      chk("count_28", 32'(free_count), 28);

      do_op("free64", 2'd1, 64);
      do_op("alloc_nextfit", 2'd0, 0);
      chk("nextfit_is_128", 32'(out_address), 128);
      while (cnt_m > 0) do_op("fill", 2'd0, 0);
      do_op("alloc_full", 2'd0, 0);
      do_op("free64_b", 2'd1, 64);
      do_op("alloc_wrap", 2'd0, 0);
      chk("wrap_is_64", 32'(out_address), 64);

      do_op("free64_c", 2'd1, 64);
      do_op("double_free", 2'd1, 64);
      do_op("free0", 2'd1, 0);
      do_op("free65", 2'd1, 65);
      do_op("op3", 2'd3, 32);

      do_op("mark64", 2'd2, 64);
      do_op("free288", 2'd1, 288);
      do_op("free320", 2'd1, 320);
      do_op("free352", 2'd1, 352);
      do_op("mark320", 2'd2, 320);
      do_op("alloc288", 2'd0, 0);
      chk("alloc_is_288", 32'(out_address), 288);
      do_op("alloc352", 2'd0, 0);
      chk("alloc_is_352", 32'(out_address), 352);
      do_op("mark320_again", 2'd2, 320);

      // headers all read as allocated while the count says blocks are free
      do_op("free96", 2'd1, 96);
      corrupt = 1;
      drive(2'd0, 0);
      chk("mismatch_ok", 32'(ok), 0);
      chk("mismatch_wren", wr, 0);
      chk("mismatch_count", 32'(free_count), cnt_m);
      chk("mismatch_addr", 32'(out_address), last_m);
      corrupt = 0;

      for (int i = 0; i < 120; i++) begin
         r = $urandom_range(0, 9);
         b = $urandom_range(0, NB - 1) * 32 + (($urandom_range(0, 7) == 0) ? 1 : 0);
         if (r < 4) do_op("rnd_alloc", 2'd0, 10'(b));
         else if (r < 7) do_op("rnd_free", 2'd1, 10'(b));
         else if (r < 9) do_op("rnd_mark", 2'd2, 10'(b));
         else do_op("rnd_op3", 2'd3, 10'(b));
      end

      for (int k = 0; k < 12; k++) do_op("pre_reset_free", 2'd1, 10'(32 * (k + 1)));
      op = 2'd0; req = 1'b1;
      @(posedge clock);
      #1 req = 1'b0;
      n = 0;
      while (!ram_wren && n < 100) begin @(negedge clock); n++; end
      chk("scan_reached_write", 32'(ram_wren), 1);
      #2 resetn = 1'b0;
      #1;
      chk("midop_wren", 32'(ram_wren), 0);
      chk("midop_ready", 32'(ready), 0);
      chk("midop_done", 32'(done), 0);
      init_check();
      do_op("post_reset_alloc", 2'd0, 0);
      chk("post_reset_is_32", 32'(out_address), 32);

      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end
endmodule
